// File: rtl/branch_resolver.sv
// Branch resolution FSM: samples the comparator equality flag, decides
// taken/not-taken, strobes the PC load and holds a pipeline flush.
module branch_resolver #(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_req,
    input  logic [1:0]        br_type,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              cmp_en,
    input  logic              cmp_in,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              taken,
    output logic              flush,
    output logic              br_done
);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        RESOLVE,
        FLUSH
    } state_t;

    localparam logic [1:0] BEQ = 2'b00;
    localparam logic [1:0] BNE = 2'b01;
    localparam logic [1:0] JMP = 2'b10;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [1:0] type_q;
    logic       cmp_q;
    logic [3:0] cnt;

    function automatic logic take_fn(input logic [1:0] t, input logic c);
        case (t)
            BEQ:     return c;
            BNE:     return ~c;
            JMP:     return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            type_q    <= 2'b00;
            cmp_q     <= 1'b0;
            cnt       <= 4'd0;
            pc_target <= '0;
            br_ready  <= 1'b1;
            cmp_en    <= 1'b0;
            pc_load   <= 1'b0;
            taken     <= 1'b0;
            flush     <= 1'b0;
            br_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (br_req) begin
                        type_q    <= br_type;
                        cmp_q     <= 1'b0;
                        pc_target <= br_target;
                        br_ready  <= 1'b0;
                        if (br_type == JMP) begin
                            state   <= RESOLVE;
                            pc_load <= 1'b1;
                            taken   <= 1'b1;
                        end else begin
                            state  <= SAMPLE;
                            cmp_en <= 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    state   <= RESOLVE;
                    cmp_q   <= cmp_in;
                    cmp_en  <= 1'b0;
                    pc_load <= take_fn(type_q, cmp_in);
                    taken   <= take_fn(type_q, cmp_in);
                    br_done <= ~take_fn(type_q, cmp_in);
                end
                RESOLVE: begin
                    pc_load <= 1'b0;
                    taken   <= 1'b0;
                    if (take_fn(type_q, cmp_q)) begin
                        state   <= FLUSH;
                        cnt     <= FLUSH_LAST;
                        flush   <= 1'b1;
                        br_done <= (FLUSH_LAST == 4'd0);
                    end else begin
                        state    <= IDLE;
                        br_done  <= 1'b0;
                        br_ready <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state    <= IDLE;
                        flush    <= 1'b0;
                        br_done  <= 1'b0;
                        br_ready <= 1'b1;
                    end else begin
                        cnt     <= cnt - 4'd1;
                        br_done <= (cnt == 4'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: per-cycle output traces against
// hand-derived masks (bit n = cycle n after the accepting edge).
module tb_branch_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       br_req;
    logic [1:0] br_type;
    logic [7:0] br_target;
    logic       cmp_in;
    logic       br_ready, cmp_en, pc_load, taken, flush, br_done;
    logic [7:0] pc_target;

    logic       b_req;
    logic [1:0] b_type;
    logic [7:0] b_target;
    logic       b_cmp;
    logic       b_ready, b_cmp_en, b_pc_load, b_taken, b_flush, b_done;
    logic [7:0] b_pc_target;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_cmp, m_load, m_taken, m_flush, m_done, m_ready;
    logic [7:0] tgt_hist [8];

    always #5 clk = ~clk;

    branch_resolver #(.ADDR_W(8), .FLUSH_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .br_req(br_req), .br_type(br_type),
        .br_target(br_target), .br_ready(br_ready), .cmp_en(cmp_en),
        .cmp_in(cmp_in), .pc_load(pc_load), .pc_target(pc_target),
        .taken(taken), .flush(flush), .br_done(br_done)
    );

    branch_resolver #(.ADDR_W(8), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .br_req(b_req), .br_type(b_type),
        .br_target(b_target), .br_ready(b_ready), .cmp_en(b_cmp_en),
        .cmp_in(b_cmp), .pc_load(b_pc_load), .pc_target(b_pc_target),
        .taken(b_taken), .flush(b_flush), .br_done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int i);
        m_cmp[i]   = cmp_en;
        m_load[i]  = pc_load;
        m_taken[i] = taken;
        m_flush[i] = flush;
        m_done[i]  = br_done;
        m_ready[i] = br_ready;
        tgt_hist[i] = pc_target;
    endtask

    task automatic run_br(input logic [1:0] t, input logic [7:0] tgt,
                          input logic c);
        br_req = 1'b1;
        br_type = t;
        br_target = tgt;
        cmp_in = c;
        rec(0);
        tick();
        br_req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            rec(i);
            if (i < 7) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        br_req = 1'b1;
        br_type = 2'b10;
        br_target = 8'hA5;
        cmp_in = 1'b0;
        b_req = 1'b1;
        b_type = 2'b10;
        b_target = 8'h5A;
        b_cmp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({br_ready, cmp_en, pc_load, taken, flush, br_done} !== 6'b100000) begin
                failures++;
                $display("FAIL reset_outputs cyc%0d: got %b want 100000", i,
                         {br_ready, cmp_en, pc_load, taken, flush, br_done});
            end
            checks++;
            if (pc_target !== 8'h00 || b_pc_target !== 8'h00) begin
                failures++;
                $display("FAIL reset_target: got %h/%h want 00/00",
                         pc_target, b_pc_target);
            end
        end
        br_req = 1'b0;
        b_req = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (br_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b/%b want 1/1",
                     br_ready, b_ready);
        end
    endtask

    task automatic check_masks(input string nm, input logic [7:0] e_cmp,
                               input logic [7:0] e_load, input logic [7:0] e_flush,
                               input logic [7:0] e_done, input logic [7:0] e_ready,
                               input logic [7:0] e_tgt);
        checks++;
        if (m_cmp !== e_cmp) begin
            failures++;
            $display("FAIL %s cmp_en: got %b want %b", nm, m_cmp, e_cmp);
        end
        checks++;
        if (m_load !== e_load || m_taken !== e_load) begin
            failures++;
            $display("FAIL %s pc_load/taken: got %b/%b want %b", nm,
                     m_load, m_taken, e_load);
        end
        checks++;
        if (m_flush !== e_flush) begin
            failures++;
            $display("FAIL %s flush: got %b want %b", nm, m_flush, e_flush);
        end
        checks++;
        if (m_done !== e_done) begin
            failures++;
            $display("FAIL %s br_done: got %b want %b", nm, m_done, e_done);
        end
        checks++;
        if (m_ready !== e_ready) begin
            failures++;
            $display("FAIL %s br_ready: got %b want %b", nm, m_ready, e_ready);
        end
        checks++;
        if (tgt_hist[2] !== e_tgt || tgt_hist[7] !== e_tgt) begin
            failures++;
            $display("FAIL %s pc_target: got %h/%h want %h", nm,
                     tgt_hist[2], tgt_hist[7], e_tgt);
        end
    endtask

    task automatic test_beq_taken();
        run_br(2'b00, 8'h3C, 1'b1);
        check_masks("beq_taken", 8'h02, 8'h04, 8'h18, 8'h10, 8'hE1, 8'h3C);
    endtask

    task automatic test_bne();
        run_br(2'b01, 8'h10, 1'b1);
        check_masks("bne_not_taken", 8'h02, 8'h00, 8'h00, 8'h04, 8'hF9, 8'h10);
        run_br(2'b01, 8'h10, 1'b0);
        check_masks("bne_taken", 8'h02, 8'h04, 8'h18, 8'h10, 8'hE1, 8'h10);
    endtask

    task automatic test_jmp_reserved();
        run_br(2'b10, 8'hFF, 1'b1);
        check_masks("jmp", 8'h00, 8'h02, 8'h0C, 8'h08, 8'hF1, 8'hFF);
        run_br(2'b11, 8'h77, 1'b1);
        check_masks("reserved", 8'h02, 8'h00, 8'h00, 8'h04, 8'hF9, 8'h77);
    endtask

    task automatic test_midop_reset();
        br_req = 1'b1;
        br_type = 2'b00;
        br_target = 8'h3C;
        cmp_in = 1'b1;
        tick();
        br_req = 1'b0;
        tick();
        tick();
        checks++;
        if (flush !== 1'b1) begin
            failures++;
            $display("FAIL midop_pre_flush: got %b want 1", flush);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({br_ready, cmp_en, pc_load, taken, flush, br_done} !== 6'b100000
            || pc_target !== 8'h00) begin
            failures++;
            $display("FAIL midop_reset: got %b tgt %h want 100000 tgt 00",
                     {br_ready, cmp_en, pc_load, taken, flush, br_done}, pc_target);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (br_done !== 1'b0 || br_ready !== 1'b1) begin
            failures++;
            $display("FAIL midop_after_release: done %b ready %b want 0 1",
                     br_done, br_ready);
        end
        run_br(2'b10, 8'h55, 1'b0);
        check_masks("jmp_after_reset", 8'h00, 8'h02, 8'h0C, 8'h08, 8'hF1, 8'h55);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_cmp, e_load, e_flush, e_done, e_ready;
        logic [7:0] o_cmp, o_load, o_flush, o_done, o_ready;
        logic [7:0] t_hist [8];
        b_req = 1'b1;
        b_type = 2'b00;
        b_target = 8'h20;
        b_cmp = 1'b1;
        e_cmp = 8'h22;
        e_load = 8'h44;
        e_flush = 8'h88;
        e_done = 8'h88;
        e_ready = 8'h11;
        o_cmp = '0;
        o_load = '0;
        o_flush = '0;
        o_done = '0;
        o_ready = '0;
        for (int i = 0; i < 8; i++) begin
            o_cmp[i] = b_cmp_en;
            o_load[i] = b_pc_load & b_taken;
            o_flush[i] = b_flush;
            o_done[i] = b_done;
            o_ready[i] = b_ready;
            t_hist[i] = b_pc_target;
            if (i == 1) b_target = 8'h44;
            if (i < 7) tick();
        end
        b_req = 1'b0;
        checks++;
        if (o_cmp !== e_cmp) begin
            failures++;
            $display("FAIL b2b cmp_en: got %b want %b", o_cmp, e_cmp);
        end
        checks++;
        if (o_load !== e_load) begin
            failures++;
            $display("FAIL b2b pc_load: got %b want %b", o_load, e_load);
        end
        checks++;
        if (o_flush !== e_flush || o_done !== e_done) begin
            failures++;
            $display("FAIL b2b flush/done: got %b/%b want %b/%b",
                     o_flush, o_done, e_flush, e_done);
        end
        checks++;
        if (o_ready !== e_ready) begin
            failures++;
            $display("FAIL b2b br_ready: got %b want %b", o_ready, e_ready);
        end
        checks++;
        if (t_hist[2] !== 8'h20 || t_hist[4] !== 8'h20 || t_hist[5] !== 8'h44) begin
            failures++;
            $display("FAIL b2b pc_target: got %h/%h/%h want 20/20/44",
                     t_hist[2], t_hist[4], t_hist[5]);
        end
        tick();
        tick();
        checks++;
        if (b_ready !== 1'b1 || b_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle_after: ready %b done %b want 1 0",
                     b_ready, b_done);
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne();
        test_jmp_reserved();
        test_midop_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
